// File: rtl/etc_tile_accumulator.sv
// etc_tile_accumulator: 4x4 tile semiring reducer (add/min/max/or); define ETC_ACC_SAT_EN for saturating add
module etc_tile_accumulator #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [CW-1:0] num_tiles,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [16*W-1:0] in_tile,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [16*W-1:0] out_tile,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    state_t state_q, state_d;
    logic [16*W-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d, num_q, num_d;
    logic [1:0] op_q, op_d;
    logic [W-1:0] red [16];
    for (genvar e = 0; e < 16; e++) begin : g_el
        logic [W-1:0] a, b, sum;
        assign a = acc_q[e*W +: W];
        assign b = in_tile[e*W +: W];
`ifdef ETC_ACC_SAT_EN
        logic [W:0] s;
        assign s = {1'b0, a} + {1'b0, b};
        assign sum = s[W] ? {W{1'b1}} : s[W-1:0];
`else
        assign sum = a + b;
`endif
        assign red[e] = op_q == 2'd0 ? sum :
                        op_q == 2'd1 ? (a < b ? a : b) :
                        op_q == 2'd2 ? (a > b ? a : b) : a | b;
    end
    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == DRAIN;
    assign busy      = state_q != IDLE;
    assign out_tile  = acc_q;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        num_d   = num_q;
        unique case (state_q)
            IDLE: if (start && num_tiles != '0) begin
                op_d    = op;
                num_d   = num_tiles;
                cnt_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: if (in_valid) begin
                cnt_d = cnt_q + 1'b1;
                // first beat loads directly, so no identity element is needed
                for (int e = 0; e < 16; e++)
                    acc_d[e*W +: W] = cnt_q == '0 ? in_tile[e*W +: W] : red[e];
                if (cnt_d == num_q) state_d = DRAIN;
            end
            DRAIN: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            num_q   <= num_d;
        end
    end
endmodule

// File: tb/tb_etc_tile_accumulator.sv
// tb_etc_tile_accumulator: random and directed jobs against a behavioural tile-reduction model
module tb_etc_tile_accumulator;
    localparam int W = 16, CW = 8, TW = 16 * W;
    logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [1:0] op = 0;
    logic [CW-1:0] num_tiles = 0;
    logic [TW-1:0] in_tile = 0;
    logic in_ready, out_valid, busy;
    logic [TW-1:0] out_tile, got;
    logic [TW-1:0] q[$];
    int n_tests = 0, n_fail = 0;

    etc_tile_accumulator #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .num_tiles(num_tiles),
        .in_valid(in_valid), .in_ready(in_ready), .in_tile(in_tile),
        .out_valid(out_valid), .out_ready(out_ready), .out_tile(out_tile), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] f(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        case (o)
`ifdef ETC_ACC_SAT_EN
            2'd0: return s > 65535 ? 16'hFFFF : 16'(s);
`else
            2'd0: return 16'(s % 65536);
`endif
            2'd1: return a < b ? a : b;
            2'd2: return a > b ? a : b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [TW-1:0] model(input logic [1:0] o);
        logic [TW-1:0] r, t;
        r = q[0];
        for (int k = 1; k < q.size(); k++) begin
            t = q[k];
            for (int e = 0; e < 16; e++) r[e*W +: W] = f(o, r[e*W +: W], t[e*W +: W]);
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] fill(input logic [W-1:0] v);
        return {16{v}};
    endfunction

    function automatic logic [TW-1:0] rnd_tile();
        logic [TW-1:0] t;
        for (int e = 0; e < 16; e++)
            case ($urandom_range(3, 0))
                0: t[e*W +: W] = 16'($urandom_range(15, 0));
                1: t[e*W +: W] = 16'hFFFF - 16'($urandom_range(3, 0));
                default: t[e*W +: W] = 16'($urandom);
            endcase
        return t;
    endfunction

    task automatic run_job(input logic [1:0] o, input int n, input int gmin, input int gmax,
                           input int bmin, input int bmax, output logic [TW-1:0] res);
        logic [TW-1:0] exp;
        int g, b;
        exp = model(o);
        op = o; num_tiles = CW'(n); start = 1;
        tick();
        start = 0; op = 2'($urandom); num_tiles = CW'($urandom);
        chk("busy_after_start", TW'(busy), 1);
        chk("in_ready_accum", TW'(in_ready), 1);
        for (int k = 0; k < n; k++) begin
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                start = 1; op = (o == 2'd2) ? 2'd1 : 2'd2;
                tick();
                chk("busy_in_gap", TW'(busy), 1);
                chk("out_valid_in_gap", TW'(out_valid), 0);
            end
            start = 0;
            in_tile = q[k]; in_valid = 1;
            tick();
            in_valid = 0; in_tile = rnd_tile();
            if (k == n - 1) begin
                chk("out_valid_latency", TW'(out_valid), 1);
                chk("in_ready_drain", TW'(in_ready), 0);
            end else chk("out_valid_early", TW'(out_valid), 0);
        end
        b = $urandom_range(bmax, bmin);
        repeat (b) begin
            tick();
            chk("hold_valid", TW'(out_valid), 1);
            chk("hold_tile", out_tile, exp);
            chk("hold_in_ready", TW'(in_ready), 0);
        end
        res = out_tile;
        chk("result", out_tile, exp);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("out_valid_after_xfer", TW'(out_valid), 0);
        chk("busy_after_xfer", TW'(busy), 0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_in_ready", TW'(in_ready), 0);
        chk("rst_out_valid", TW'(out_valid), 0);
        chk("rst_busy", TW'(busy), 0);
        chk("rst_out_tile", out_tile, 0);
        rst_n = 1;
        tick();

        q = {fill(16'h0001), fill(16'h0002)};
        run_job(2'd0, 2, 0, 0, 0, 0, got);
        chk("add_const", got, fill(16'h0003));

        q = {fill(16'd5), fill(16'd3), fill(16'd7)};
        run_job(2'd1, 3, 2, 2, 0, 0, got);
        chk("min_const", got, fill(16'd3));

        q = {fill(16'd9), fill(16'd4)};
        run_job(2'd2, 2, 0, 0, 3, 3, got);
        chk("max_const", got, fill(16'd9));

        q = {fill(16'hFFFF), fill(16'h0002)};
        run_job(2'd0, 2, 0, 0, 0, 0, got);
`ifdef ETC_ACC_SAT_EN
        chk("overflow_const", got, fill(16'hFFFF));
`else
        chk("overflow_const", got, fill(16'h0001));
`endif

        q = {fill(16'd3), fill(16'd5)};
        run_job(2'd0, 2, 1, 1, 0, 0, got);
        chk("midjob_start_keeps_op", got, fill(16'd8));

        op = 2'd3; num_tiles = 3; start = 1;
        tick();
        start = 0; in_tile = fill(16'h1234); in_valid = 1;
        tick();
        in_valid = 0; rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst_in_ready", TW'(in_ready), 0);
        chk("midrst_busy", TW'(busy), 0);
        chk("midrst_out_valid", TW'(out_valid), 0);
        chk("midrst_out_tile", out_tile, 0);
        q = {fill(16'h00F0), fill(16'h000F)};
        run_job(2'd3, 2, 0, 0, 0, 0, got);
        chk("after_rst_job", got, fill(16'h00FF));

        op = 2'd0; num_tiles = 0; start = 1;
        tick();
        start = 0;
        chk("zero_start_busy", TW'(busy), 0);
        chk("zero_start_in_ready", TW'(in_ready), 0);
        tick();
        chk("zero_start_idle", TW'(busy), 0);

        for (int j = 0; j < 40; j++) begin
            int n;
            logic [1:0] o;
            n = (j % 8 == 0) ? 1 : $urandom_range(6, 1);
            o = 2'($urandom);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(rnd_tile());
            run_job(o, n, 0, 2, 0, 3, got);
            if (n == 1) chk("single_tile_passthru", got, q[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
